// File: rtl/rvfi_ob_pkg.sv
// Shared types and helpers for the RVFI order buffer: packed retirement record
// layout, field offsets and slot indexing.
package rvfi_ob_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int ORDER_W_DEF = 8;
  localparam int DEPTH_DEF   = 8;
  localparam int NRET_DEF    = 2;

  function automatic int rec_w(input int xlen);
    return 48 + 8 * xlen + xlen / 4;
  endfunction

  localparam int REC_W = rec_w(XLEN_DEF);

  // Field offsets, LSB first; insn occupies the top 32 bits.
  localparam int OFF_MEM_WDATA = 0;
  localparam int OFF_MEM_RDATA = OFF_MEM_WDATA + XLEN_DEF;
  localparam int OFF_MEM_WMASK = OFF_MEM_RDATA + XLEN_DEF;
  localparam int OFF_MEM_RMASK = OFF_MEM_WMASK + XLEN_DEF / 8;
  localparam int OFF_MEM_ADDR  = OFF_MEM_RMASK + XLEN_DEF / 8;
  localparam int OFF_TRAP      = OFF_MEM_ADDR + XLEN_DEF;
  localparam int OFF_POST_RD   = OFF_TRAP + 1;
  localparam int OFF_POST_PC   = OFF_POST_RD + XLEN_DEF;
  localparam int OFF_RS2_RDATA = OFF_POST_PC + XLEN_DEF;
  localparam int OFF_RS1_RDATA = OFF_RS2_RDATA + XLEN_DEF;
  localparam int OFF_PRE_PC    = OFF_RS1_RDATA + XLEN_DEF;
  localparam int OFF_RD_ADDR   = OFF_PRE_PC + XLEN_DEF;
  localparam int OFF_RS2_ADDR  = OFF_RD_ADDR + 5;
  localparam int OFF_RS1_ADDR  = OFF_RS2_ADDR + 5;
  localparam int OFF_INSN      = OFF_RS1_ADDR + 5;

  typedef struct packed {
    logic [31:0]           insn;
    logic [4:0]            rs1_addr;
    logic [4:0]            rs2_addr;
    logic [4:0]            rd_addr;
    logic [XLEN_DEF-1:0]   pre_pc;
    logic [XLEN_DEF-1:0]   rs1_rdata;
    logic [XLEN_DEF-1:0]   rs2_rdata;
    logic [XLEN_DEF-1:0]   post_pc;
    logic [XLEN_DEF-1:0]   post_rd;
    logic                  trap;
    logic [XLEN_DEF-1:0]   mem_addr;
    logic [XLEN_DEF/8-1:0] mem_rmask;
    logic [XLEN_DEF/8-1:0] mem_wmask;
    logic [XLEN_DEF-1:0]   mem_rdata;
    logic [XLEN_DEF-1:0]   mem_wdata;
  } rvfi_rec_t;

  function automatic logic [REC_W-1:0] pack_rec(input rvfi_rec_t s);
    logic [REC_W-1:0] r;
    r = '0;
    r[OFF_INSN +: 32]               = s.insn;
    r[OFF_RS1_ADDR +: 5]            = s.rs1_addr;
    r[OFF_RS2_ADDR +: 5]            = s.rs2_addr;
    r[OFF_RD_ADDR +: 5]             = s.rd_addr;
    r[OFF_PRE_PC +: XLEN_DEF]       = s.pre_pc;
    r[OFF_RS1_RDATA +: XLEN_DEF]    = s.rs1_rdata;
    r[OFF_RS2_RDATA +: XLEN_DEF]    = s.rs2_rdata;
    r[OFF_POST_PC +: XLEN_DEF]      = s.post_pc;
    r[OFF_POST_RD +: XLEN_DEF]      = s.post_rd;
    r[OFF_TRAP]                     = s.trap;
    r[OFF_MEM_ADDR +: XLEN_DEF]     = s.mem_addr;
    r[OFF_MEM_RMASK +: XLEN_DEF/8]  = s.mem_rmask;
    r[OFF_MEM_WMASK +: XLEN_DEF/8]  = s.mem_wmask;
    r[OFF_MEM_RDATA +: XLEN_DEF]    = s.mem_rdata;
    r[OFF_MEM_WDATA +: XLEN_DEF]    = s.mem_wdata;
    return r;
  endfunction

  function automatic rvfi_rec_t unpack_rec(input logic [REC_W-1:0] r);
    rvfi_rec_t s;
    s.insn      = r[OFF_INSN +: 32];
    s.rs1_addr  = r[OFF_RS1_ADDR +: 5];
    s.rs2_addr  = r[OFF_RS2_ADDR +: 5];
    s.rd_addr   = r[OFF_RD_ADDR +: 5];
    s.pre_pc    = r[OFF_PRE_PC +: XLEN_DEF];
    s.rs1_rdata = r[OFF_RS1_RDATA +: XLEN_DEF];
    s.rs2_rdata = r[OFF_RS2_RDATA +: XLEN_DEF];
    s.post_pc   = r[OFF_POST_PC +: XLEN_DEF];
    s.post_rd   = r[OFF_POST_RD +: XLEN_DEF];
    s.trap      = r[OFF_TRAP];
    s.mem_addr  = r[OFF_MEM_ADDR +: XLEN_DEF];
    s.mem_rmask = r[OFF_MEM_RMASK +: XLEN_DEF/8];
    s.mem_wmask = r[OFF_MEM_WMASK +: XLEN_DEF/8];
    s.mem_rdata = r[OFF_MEM_RDATA +: XLEN_DEF];
    s.mem_wdata = r[OFF_MEM_WDATA +: XLEN_DEF];
    return s;
  endfunction

  // Slot index of an order: its low bits (depth is a power of two).
  function automatic logic [31:0] slot_of(input logic [31:0] order, input int depth);
    return order & (32'(depth) - 32'd1);
  endfunction

endpackage

// File: rtl/rvfi_ob_run_select.sv
// Finds how many consecutive valid slots start at the expected order (capped at
// the lane count) and which slot feeds each output lane.
module rvfi_ob_run_select import rvfi_ob_pkg::*; #(
  parameter int NRET    = NRET_DEF,
  parameter int ORDER_W = ORDER_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(NRET + 1)
) (
  input  logic [DEPTH-1:0]            slot_vld,
  input  logic [ORDER_W-1:0]          exp_order,
  output logic [CNT_W-1:0]            run_len,
  output logic [NRET-1:0][IDX_W-1:0]  lane_idx
);

  logic run_broken;

  // Walk lanes from the expected order; the run ends at the first empty slot.
  always_comb begin
    run_len    = '0;
    lane_idx   = '0;
    run_broken = 1'b0;
    for (int k = 0; k < NRET; k++) begin
      lane_idx[k] = IDX_W'(slot_of(32'(exp_order) + 32'(k), DEPTH));
      if (!run_broken && slot_vld[lane_idx[k]]) begin
        run_len = CNT_W'(k + 1);
      end else begin
        run_broken = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvfi_order_buffer.sv
// Reorders RVFI retirements arriving out of order into a strictly increasing
// rvfi_order stream on NRET registered lanes, with sticky window/duplicate errors.
module rvfi_order_buffer import rvfi_ob_pkg::*; #(
  parameter int NRET     = NRET_DEF,
  parameter int XLEN     = XLEN_DEF,
  parameter int ORDER_W  = ORDER_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  localparam int REC_BITS = rec_w(XLEN),
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(NRET + 1)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NRET-1:0]           in_valid,
  input  logic [NRET*ORDER_W-1:0]   in_order,
  input  logic [NRET*REC_BITS-1:0]  in_rec,
  output logic [NRET-1:0]           out_valid,
  output logic [NRET*ORDER_W-1:0]   out_order,
  output logic [NRET*REC_BITS-1:0]  out_rec,
  output logic                      err_window,
  output logic                      err_dup
);

  localparam logic [ORDER_W:0] DEPTH_W = (ORDER_W + 1)'(DEPTH);

  logic [DEPTH-1:0]                slot_vld;
  logic [REC_BITS-1:0]             slot_rec [DEPTH];
  logic [ORDER_W-1:0]              exp_order;

  logic [CNT_W-1:0]                run_len;
  logic [NRET-1:0][IDX_W-1:0]      lane_idx;

  logic [NRET-1:0]                 wr_en;
  logic [NRET-1:0]                 win_err;
  logic [NRET-1:0]                 dup_err;
  logic [NRET-1:0][IDX_W-1:0]      wr_idx;
  logic [ORDER_W-1:0]              lane_ord;
  logic [ORDER_W-1:0]              lane_dist;
  logic                            lane_clash;

  rvfi_ob_run_select #(
    .NRET    (NRET),
    .ORDER_W (ORDER_W),
    .DEPTH   (DEPTH)
  ) u_run_select (
    .slot_vld  (slot_vld),
    .exp_order (exp_order),
    .run_len   (run_len),
    .lane_idx  (lane_idx)
  );

  // Classify each input lane: out of window, duplicate (lower lane wins), or write.
  always_comb begin
    wr_en      = '0;
    win_err    = '0;
    dup_err    = '0;
    wr_idx     = '0;
    lane_ord   = '0;
    lane_dist  = '0;
    lane_clash = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      lane_ord   = in_order[i*ORDER_W +: ORDER_W];
      lane_dist  = lane_ord - exp_order;
      wr_idx[i]  = IDX_W'(slot_of(32'(lane_ord), DEPTH));
      lane_clash = slot_vld[wr_idx[i]];
      for (int j = 0; j < NRET; j++) begin
        if (j < i && in_valid[j] && in_order[j*ORDER_W +: ORDER_W] == lane_ord) begin
          lane_clash = 1'b1;
        end
      end
      if (in_valid[i]) begin
        if ({1'b0, lane_dist} >= DEPTH_W) begin
          win_err[i] = 1'b1;
        end else if (lane_clash) begin
          dup_err[i] = 1'b1;
        end else begin
          wr_en[i] = 1'b1;
        end
      end
    end
  end

  // Drain the in-order run to the output lanes, mark new writes, advance exp_order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_vld   <= '0;
      exp_order  <= '0;
      out_valid  <= '0;
      out_order  <= '0;
      out_rec    <= '0;
      err_window <= 1'b0;
      err_dup    <= 1'b0;
    end else begin
      for (int k = 0; k < NRET; k++) begin
        if (CNT_W'(k) < run_len) begin
          out_valid[k]                     <= 1'b1;
          out_order[k*ORDER_W +: ORDER_W]  <= exp_order + ORDER_W'(k);
          out_rec[k*REC_BITS +: REC_BITS]  <= slot_rec[lane_idx[k]];
          slot_vld[lane_idx[k]]            <= 1'b0;
        end else begin
          out_valid[k]                     <= 1'b0;
          out_order[k*ORDER_W +: ORDER_W]  <= '0;
          out_rec[k*REC_BITS +: REC_BITS]  <= '0;
        end
      end
      for (int i = 0; i < NRET; i++) begin
        if (wr_en[i]) begin
          slot_vld[wr_idx[i]] <= 1'b1;
        end
      end
      exp_order <= exp_order + ORDER_W'(run_len);
      if (|win_err) begin
        err_window <= 1'b1;
      end
      if (|dup_err) begin
        err_dup <= 1'b1;
      end
    end
  end

  // Record storage; validity is tracked separately, so the payload needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NRET; i++) begin
      if (wr_en[i]) begin
        slot_rec[wr_idx[i]] <= in_rec[i*REC_BITS +: REC_BITS];
      end
    end
  end

endmodule
